dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the latency-programmable data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // Misaligned or beyond the last word of the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with a byte-enabled write port and an asynchronous read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AddrW-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are intentionally not reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed programmable response latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ready_en_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept, commit, arr_we;
    logic              cur_we, cur_err;
    logic [31:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata, arr_rdata;
    logic [BE_W-1:0]   cur_be;

    // With LATENCY == 1 the commit happens on the accept edge, before the latch holds the request.
    always_comb begin
        cur_we    = (state_q == StIdle) ? req_we_i    : we_q;
        cur_addr  = (state_q == StIdle) ? req_addr_i  : addr_q;
        cur_wdata = (state_q == StIdle) ? req_wdata_i : wdata_q;
        cur_be    = (state_q == StIdle) ? req_be_i    : be_q;
        cur_err   = addr_err(cur_addr, DEPTH);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        accept  = (state_q == StIdle) && ready_en_q && req_valid_i;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntW'(LATENCY - 2);
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        arr_we = commit && cur_we && !cur_err;
        if (commit) begin
            err_d   = cur_err;
            rdata_d = (!cur_we && !cur_err) ? arr_rdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            if (accept) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .be_i    (cur_be),
        .addr_i  (cur_addr[AddrW+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (arr_rdata)
    );

    // ready_en_q keeps req_ready low during reset without a path from rst_ni to the output.
    assign req_ready_o = (state_q == StIdle) && ready_en_q;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule
